// File: rtl/bypass_network.sv
// bypass_network: forwards in-flight producer results to consumer sources and detects load-use hazards.
module bypass_network #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        freeze,
  input  logic                        wr_valid,
  input  logic [REG_AW-1:0]           wr_reg,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        wr_is_load,
  input  logic [DATA_W-1:0]           ld_data,
  input  logic [NUM_SRC*REG_AW-1:0]   src_reg,
  input  logic [NUM_SRC*DATA_W-1:0]   src_rf_data,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
  output logic [NUM_SRC-1:0]          fwd_hit,
  output logic [NUM_SRC*3-1:0]        fwd_slot,
  output logic                        hazard_stall,
  output logic [15:0]                 stall_count
);
  logic [DEPTH-1:0]   v, p;
  logic [REG_AW-1:0]  r [DEPTH];
  logic [DATA_W-1:0]  d [DEPTH];
  logic [NUM_SRC-1:0] m_any, m_pend;
  logic [2:0]         m_idx [NUM_SRC];
  logic [DATA_W-1:0]  m_data [NUM_SRC];
  // Scan oldest to youngest so the youngest matching slot is the one left standing.
  always_comb begin
    m_any = '0;
    m_pend = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      m_idx[i] = '0;
      m_data[i] = '0;
      for (int k = DEPTH - 1; k >= 0; k--)
        if (v[k] && r[k] == src_reg[i*REG_AW +: REG_AW] && src_reg[i*REG_AW +: REG_AW] != '0) begin
          m_any[i] = 1'b1;
          m_pend[i] = p[k];
          m_idx[i] = 3'(k);
          m_data[i] = d[k];
        end
    end
  end
  always_comb begin
    fwd_data = src_rf_data;
    fwd_slot = '0;
    fwd_hit = m_any & ~m_pend;
    hazard_stall = |(m_any & m_pend);
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_data[i*DATA_W +: DATA_W] = fwd_hit[i] ? m_data[i] : src_rf_data[i*DATA_W +: DATA_W];
      fwd_slot[i*3 +: 3] = fwd_hit[i] ? m_idx[i] : 3'd0;
    end
  end
  // A pending load resolves as it moves from slot 0 to slot 1, so only slot 0 can ever be pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      p <= '0;
      stall_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r[k] <= '0;
        d[k] <= '0;
      end
    end else if (!freeze) begin
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= v[k-1];
        r[k] <= r[k-1];
        d[k] <= (k == 1 && p[0]) ? ld_data : d[k-1];
        p[k] <= (k == 1) ? 1'b0 : p[k-1];
      end
      v[0] <= !hazard_stall && wr_valid;
      r[0] <= hazard_stall ? '0 : wr_reg;
      d[0] <= hazard_stall ? '0 : wr_data;
      p[0] <= !hazard_stall && wr_valid && wr_is_load;
      if (hazard_stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_bypass_network.sv
// tb_bypass_network: table-driven vectors plus hand-built sequences, checked through an expectation queue.
module tb_bypass_network;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int DP = 3;
  localparam logic [31:0] R0 = 32'h1000;
  localparam logic [31:0] R1 = 32'h2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic freeze = 1'b0;
  logic wr_valid = 1'b0;
  logic [AW-1:0] wr_reg = '0;
  logic [DW-1:0] wr_data = '0;
  logic wr_is_load = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic [NS*AW-1:0] src_reg = '0;
  logic [NS*DW-1:0] src_rf_data = '0;
  logic [NS*DW-1:0] fwd_data;
  logic [NS-1:0] fwd_hit;
  logic [NS*3-1:0] fwd_slot;
  logic hazard_stall;
  logic [15:0] stall_count;

  bypass_network #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .wr_valid(wr_valid), .wr_reg(wr_reg),
    .wr_data(wr_data), .wr_is_load(wr_is_load), .ld_data(ld_data), .src_reg(src_reg),
    .src_rf_data(src_rf_data), .fwd_data(fwd_data), .fwd_hit(fwd_hit), .fwd_slot(fwd_slot),
    .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic frz, wv;
    logic [4:0] wr;
    logic [31:0] wd;
    logic wl;
    logic [31:0] ld;
    logic [4:0] s0, s1;
    logic [31:0] rf0, rf1, ed0, ed1;
    logic [1:0] eh;
    logic [2:0] es0, es1;
    logic est;
    logic [15:0] esc;
  } vec_t;

  vec_t q[$];
  vec_t tbl[15];
  int checks = 0;
  int errors = 0;
  int step_no = 0;

  function automatic vec_t mk(input logic frz, wv, input logic [4:0] wr, input logic [31:0] wd,
                              input logic wl, input logic [31:0] ld, input logic [4:0] s0, s1,
                              input logic [31:0] rf0, rf1, ed0, ed1, input logic [1:0] eh,
                              input logic [2:0] es0, es1, input logic est, input logic [15:0] esc);
    vec_t v;
    v.frz = frz; v.wv = wv; v.wr = wr; v.wd = wd; v.wl = wl; v.ld = ld;
    v.s0 = s0; v.s1 = s1; v.rf0 = rf0; v.rf1 = rf1; v.ed0 = ed0; v.ed1 = ed1;
    v.eh = eh; v.es0 = es0; v.es1 = es1; v.est = est; v.esc = esc;
    return v;
  endfunction

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h, expected %h", step_no, n, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    freeze = v.frz; wr_valid = v.wv; wr_reg = v.wr; wr_data = v.wd; wr_is_load = v.wl;
    ld_data = v.ld; src_reg = {v.s1, v.s0}; src_rf_data = {v.rf1, v.rf0};
    q.push_back(v);
  endtask

  task automatic check();
    vec_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL step %0d scoreboard: got empty queue, expected an entry", step_no);
      return;
    end
    e = q.pop_front();
    cmp("fwd_data0", fwd_data[31:0], e.ed0);
    cmp("fwd_data1", fwd_data[63:32], e.ed1);
    cmp("fwd_hit", 32'(fwd_hit), 32'(e.eh));
    cmp("fwd_slot0", 32'(fwd_slot[2:0]), 32'(e.es0));
    cmp("fwd_slot1", 32'(fwd_slot[5:3]), 32'(e.es1));
    cmp("hazard_stall", 32'(hazard_stall), 32'(e.est));
    cmp("stall_count", 32'(stall_count), 32'(e.esc));
    step_no++;
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check();
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mk(0,1,3,'h11,0,0,       3,0, R0,R1, R0,R1,       2'b00,0,0,0,0);
    tbl[1]  = mk(0,1,3,'h22,0,0,       3,4, R0,R1, 'h11,R1,     2'b01,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,0,          3,3, R0,R1, 'h22,'h22,   2'b11,0,0,0,0);
    tbl[3]  = mk(0,0,0,0,0,0,          3,9, R0,R1, 'h22,R1,     2'b01,1,0,0,0);
    tbl[4]  = mk(0,0,0,0,0,0,          3,9, R0,R1, 'h22,R1,     2'b01,2,0,0,0);
    tbl[5]  = mk(0,0,0,0,0,0,          3,9, R0,R1, R0,R1,       2'b00,0,0,0,0);
    tbl[6]  = mk(0,1,5,'hDEAD,1,0,     5,0, R0,R1, R0,R1,       2'b00,0,0,0,0);
    tbl[7]  = mk(0,1,6,'h66,0,'hABCD,  5,6, R0,R1, R0,R1,       2'b00,0,0,1,0);
    tbl[8]  = mk(0,0,0,0,0,0,          5,6, R0,R1, 'hABCD,R1,   2'b01,1,0,0,1);
    tbl[9]  = mk(0,1,0,'hFF,0,0,       0,5, 0,R1,  0,'hABCD,    2'b10,0,2,0,1);
    tbl[10] = mk(0,0,0,0,0,0,          0,0, 0,R1,  0,R1,        2'b00,0,0,0,1);
    tbl[11] = mk(0,1,8,0,1,0,          1,2, R0,R1, R0,R1,       2'b00,0,0,0,1);
    tbl[12] = mk(1,0,0,0,0,'h5555,     1,8, R0,R1, R0,R1,       2'b00,0,0,1,1);
    tbl[13] = mk(0,0,0,0,0,'h5555,     1,8, R0,R1, R0,R1,       2'b00,0,0,1,1);
    tbl[14] = mk(0,0,0,0,0,0,          1,8, R0,R1, R0,'h5555,   2'b10,0,1,0,2);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step(tbl[i]);

    // r7 written, held by freeze (new writes ignored), then aged out over DEPTH advances
    step(mk(0,1,7,'h77,0,0, 7,0, R0,R1, R0,R1, 2'b00,0,0,0,2));
    for (int i = 0; i < 5; i++) step(mk(1,1,7,'h99,0,0, 7,0, R0,R1, 'h77,R1, 2'b01,0,0,0,2));
    for (int k = 0; k < DP; k++) step(mk(0,0,0,0,0,0, 7,0, R0,R1, 'h77,R1, 2'b01,3'(k),0,0,2));
    step(mk(0,0,0,0,0,0, 7,0, R0,R1, R0,R1, 2'b00,0,0,0,2));

    // asynchronous reset while a load-use stall is active
    step(mk(0,1,5,0,1,0, 5,0, R0,R1, R0,R1, 2'b00,0,0,0,2));
    step(mk(0,0,0,0,0,0, 5,0, R0,R1, R0,R1, 2'b00,0,0,1,2));
    #1 rst_n = 1'b0;
    v = mk(0,0,0,0,0,0, 5,0, R0,R1, R0,R1, 2'b00,0,0,0,0);
    q.push_back(v);
    #1 check();
    #1 rst_n = 1'b1;
    step(mk(0,1,5,'h3C,0,0, 5,0, R0,R1, R0,R1, 2'b00,0,0,0,0));
    step(mk(0,0,0,0,0,0, 5,5, R0,R1, 'h3C,'h3C, 2'b11,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
